// File: rtl/array_packed_3d_pkg.sv
// rtl/array_packed_3d_pkg.sv - shared types and defaults for the packed 3D array assembler
//
// Purpose: default dimensions, FSM state encoding, element/array typedefs and
//          an index-width helper used by the assembler and its index counter.
// Ports:   none (package).

package array_packed_3d_pkg;

    localparam int DEF_DI = 4;
    localparam int DEF_DJ = 3;
    localparam int DEF_DK = 2;
    localparam int DEF_DW = 8;
    localparam int DEF_CW = 16;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef logic [DEF_DW-1:0] elem_t;

    typedef logic [DEF_DI-1:0][DEF_DJ-1:0][DEF_DK-1:0][DEF_DW-1:0] array_t;

    // A dimension of size 1 still gets a 1-bit counter that simply never moves.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/array_packed_3d_index.sv
// rtl/array_packed_3d_index.sv - nested i/j/k element index counter
//
// Purpose: walks i/j/k in row-major order (k fastest, then j, then i),
//          wrapping back to [0][0][0] after the final element.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   inc    in   advance to the next element
//   clr    in   synchronous return to [0][0][0]; wins over inc
//   i,j,k  out  current element index
//   last   out  current index is the final element [DI-1][DJ-1][DK-1]

module array_packed_3d_index
    import array_packed_3d_pkg::*;
#(
    parameter int DI = DEF_DI,
    parameter int DJ = DEF_DJ,
    parameter int DK = DEF_DK,
    parameter int IW = idx_width(DI),
    parameter int JW = idx_width(DJ),
    parameter int KW = idx_width(DK)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [IW-1:0] i,
    output logic [JW-1:0] j,
    output logic [KW-1:0] k,
    output logic          last
);

    localparam logic [IW-1:0] I_MAX = IW'(DI - 1);
    localparam logic [JW-1:0] J_MAX = JW'(DJ - 1);
    localparam logic [KW-1:0] K_MAX = KW'(DK - 1);

    logic [IW-1:0] i_q, i_d;
    logic [JW-1:0] j_q, j_d;
    logic [KW-1:0] k_q, k_d;

    // A size-1 dimension has MAX == 0, so it wraps on every carry and never
    // leaves zero; no special casing is needed.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (clr) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else if (inc) begin
            if (k_q == K_MAX) begin
                k_d = '0;
                if (j_q == J_MAX) begin
                    j_d = '0;
                    if (i_q == I_MAX) begin
                        i_d = '0;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    j_d = j_q + JW'(1);
                end
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

    assign i    = i_q;
    assign j    = j_q;
    assign k    = k_q;
    assign last = (i_q == I_MAX) && (j_q == J_MAX) && (k_q == K_MAX);

endmodule

// File: rtl/array_packed_3d_assembler.sv
// rtl/array_packed_3d_assembler.sv - builds a packed 3D array from a scalar element stream
//
// Purpose: accepts one DW-bit element per s_valid/s_ready handshake, writes it
//          to m_array[i][j][k] (k fastest), and after the final element
//          presents the whole array on m_valid/m_ready. frames counts handoffs.
//          Optional macro ARRAY_PACKED_3D_ASSEMBLER_ZERO_BUBBLE_EN lets the first
//          element of the next frame be accepted in the same cycle as the handoff.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   s_valid  in   element valid
//   s_ready  out  element ready
//   s_data   in   element value (DW)
//   m_valid  out  array valid
//   m_ready  in   array ready
//   m_array  out  packed array [DI-1:0][DJ-1:0][DK-1:0][DW-1:0]
//   frames   out  completed handoff count, wraps modulo 2^CW
//   busy     out  current frame partially filled

module array_packed_3d_assembler
    import array_packed_3d_pkg::*;
#(
    parameter int DI = DEF_DI,
    parameter int DJ = DEF_DJ,
    parameter int DK = DEF_DK,
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DW-1:0]          s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DI*DJ*DK*DW-1:0] m_array,
    output logic [CW-1:0]          frames,
    output logic                   busy
);

    localparam int IW = idx_width(DI);
    localparam int JW = idx_width(DJ);
    localparam int KW = idx_width(DK);

    state_t state_q, state_d;
    logic [DI-1:0][DJ-1:0][DK-1:0][DW-1:0] arr_q, arr_d;
    logic [CW-1:0] frames_q, frames_d;

    logic [IW-1:0] idx_i;
    logic [JW-1:0] idx_j;
    logic [KW-1:0] idx_k;
    logic          idx_last;
    logic          idx_inc;
    logic          idx_clr;

    array_packed_3d_index #(
        .DI (DI),
        .DJ (DJ),
        .DK (DK),
        .IW (IW),
        .JW (JW),
        .KW (KW)
    ) u_index (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (idx_inc),
        .clr   (idx_clr),
        .i     (idx_i),
        .j     (idx_j),
        .k     (idx_k),
        .last  (idx_last)
    );

    always_comb begin
        state_d  = state_q;
        arr_d    = arr_q;
        frames_d = frames_q;
        s_ready  = 1'b0;
        m_valid  = 1'b0;
        idx_inc  = 1'b0;
        idx_clr  = 1'b0;
        case (state_q)
            FILL: begin
                // rst_n gates ready so no handshake is advertised during reset.
                s_ready = rst_n;
                if (s_valid && s_ready) begin
                    arr_d[idx_i][idx_j][idx_k] = s_data;
                    if (idx_last) begin
                        idx_clr = 1'b1;
                        state_d = HOLD;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            HOLD: begin
                m_valid = 1'b1;
`ifdef ARRAY_PACKED_3D_ASSEMBLER_ZERO_BUBBLE_EN
                s_ready = m_ready && rst_n;
`endif
                if (m_ready) begin
                    frames_d = frames_q + CW'(1);
                    state_d  = FILL;
`ifdef ARRAY_PACKED_3D_ASSEMBLER_ZERO_BUBBLE_EN
                    // Indices already sit at [0][0][0] while holding; advancing
                    // them lands on the second element, or wraps straight back
                    // to zero for a single-element array (which is then full).
                    if (s_valid) begin
                        arr_d[0][0][0] = s_data;
                        idx_inc        = 1'b1;
                        if (idx_last) begin
                            state_d = HOLD;
                        end
                    end
`endif
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            arr_q    <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            arr_q    <= arr_d;
            frames_q <= frames_d;
        end
    end

    assign m_array = arr_q;
    assign frames  = frames_q;
    assign busy    = (state_q == FILL) && ((|idx_i) || (|idx_j) || (|idx_k));

endmodule

// File: tb/tb_array_packed_3d_assembler.sv
// tb/tb_array_packed_3d_assembler.sv - self-checking bench for array_packed_3d_assembler

module tb_array_packed_3d_assembler;

    localparam int DI = 4;
    localparam int DJ = 3;
    localparam int DK = 2;
    localparam int DW = 8;
    localparam int NE = DI * DJ * DK;
    localparam int AW = NE * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          m_ready;
    logic [DW-1:0] s_data;

    logic          s_ready, m_valid, busy;
    logic [AW-1:0] m_array;
    logic [15:0]   frames;

    logic          s_ready_w, m_valid_w, busy_w;
    logic [AW-1:0] m_array_w;
    logic [1:0]    frames_w;

    array_packed_3d_assembler #(.DI(DI), .DJ(DJ), .DK(DK), .DW(DW), .CW(16)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_array (m_array),
        .frames  (frames),
        .busy    (busy)
    );

    array_packed_3d_assembler #(.DI(DI), .DJ(DJ), .DK(DK), .DW(DW), .CW(2)) u_dut_w (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready_w),
        .s_data  (s_data),
        .m_valid (m_valid_w),
        .m_ready (m_ready),
        .m_array (m_array_w),
        .frames  (frames_w),
        .busy    (busy_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: an array of elements, a count of accepted elements in
    // the current frame, a holding flag and a handoff counter.
    logic [DW-1:0] marr [DI][DJ][DK];
    int  mn;
    bit  mhold;
    int  mframes;
    int  hs_cnt;

    task automatic model_reset();
        for (int a = 0; a < DI; a++)
            for (int b = 0; b < DJ; b++)
                for (int c = 0; c < DK; c++)
                    marr[a][b][c] = '0;
        mn      = 0;
        mhold   = 0;
        mframes = 0;
    endtask

    function automatic logic [AW-1:0] pack_model();
        logic [AW-1:0] p;
        p = '0;
        for (int a = 0; a < DI; a++)
            for (int b = 0; b < DJ; b++)
                for (int c = 0; c < DK; c++)
                    p[((a * DJ + b) * DK + c) * DW +: DW] = marr[a][b][c];
        return p;
    endfunction

    function automatic logic [DW-1:0] elem(input logic [AW-1:0] arr, input int a, input int b, input int c);
        return arr[((a * DJ + b) * DK + c) * DW +: DW];
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare all
    // outputs against the model, then let the model follow the handshakes.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic mr);
        logic exp_sr;
        bit   hin, hout;
        s_valid = v;
        s_data  = d;
        m_ready = mr;
        #1;
        exp_sr = !mhold;
`ifdef ARRAY_PACKED_3D_ASSEMBLER_ZERO_BUBBLE_EN
        if (mhold) exp_sr = mr;
`endif
        check_val("s_ready", AW'(s_ready), AW'(exp_sr));
        check_val("m_valid", AW'(m_valid), AW'(mhold));
        check_val("busy", AW'(busy), AW'(!mhold && mn != 0));
        check_val("m_array", m_array, pack_model());
        check_val("frames", AW'(frames), AW'(mframes % 65536));
        check_val("w_frames", AW'(frames_w), AW'(mframes % 4));
        check_val("w_array", m_array_w, pack_model());
        check_val("w_hs", AW'({s_ready_w, m_valid_w, busy_w}), AW'({s_ready, m_valid, busy}));
        hin  = v && exp_sr;
        hout = mhold && mr;
        @(posedge clk);
        if (hout) begin
            mframes++;
            mhold = 0;
        end
        if (hin) begin
            hs_cnt++;
            marr[mn / (DJ * DK)][(mn / DK) % DJ][mn % DK] = d;
            mn++;
            if (mn == NE) begin
                mn    = 0;
                mhold = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        s_valid = 1'b1;
        m_ready = 1'b1;
        rst_n   = 1'b0;
        #1;
        check_val("rst_s_ready", AW'(s_ready), '0);
        check_val("rst_m_valid", AW'(m_valid), '0);
        check_val("rst_busy", AW'(busy), '0);
        check_val("rst_m_array", m_array, '0);
        check_val("rst_frames", AW'(frames), '0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b0;
    endtask

    // Fill one frame with random gaps and data, then hand it off under
    // random backpressure; both loops are bounded.
    task automatic run_frame(input string tag);
        int guard;
        guard = 0;
        while (!mhold && guard < 400) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
            guard++;
        end
        check_val({tag, "_fill_bound"}, AW'(guard < 400), AW'(1));
        guard = 0;
        while (mhold && guard < 100) begin
            cycle(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
            guard++;
        end
        check_val({tag, "_drain_bound"}, AW'(guard < 100), AW'(1));
    endtask

    logic [1:0] wrap_seq [5];
    int guard;

    initial begin
        wrap_seq[0] = 2'd1; wrap_seq[1] = 2'd2; wrap_seq[2] = 2'd3;
        wrap_seq[3] = 2'd0; wrap_seq[4] = 2'd1;
        rst_n   = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = '0;
        hs_cnt  = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Full frame with value i+j+k.
        for (int n = 0; n < NE; n++)
            cycle(1'b1, 8'((n / (DJ * DK)) + ((n / DK) % DJ) + (n % DK)), 1'b1);
        check_val("full_m_valid", AW'(m_valid), AW'(1));
        check_val("full_321", AW'(elem(m_array, 3, 2, 1)), AW'(6));
        check_val("full_000", AW'(elem(m_array, 0, 0, 0)), AW'(0));
        check_val("full_210", AW'(elem(m_array, 2, 1, 0)), AW'(3));
        cycle(1'b0, 8'h00, 1'b1);
        check_val("full_frames", AW'(frames), AW'(1));

        // Backpressure: five held cycles, then release.
        for (int n = 0; n < NE; n++)
            cycle(1'b1, 8'($urandom), 1'b1);
        for (int n = 0; n < 5; n++)
            cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Gaps with 0xA0 + linear element number.
        guard = 0;
        while (!mhold && guard < 400) begin
            cycle(1'($urandom_range(0, 1)), 8'(8'hA0 + mn), 1'b1);
            guard++;
        end
        check_val("gap_bound", AW'(guard < 400), AW'(1));
        check_val("gap_211", AW'(elem(m_array, 2, 1, 1)), AW'(8'hAF));
        check_val("gap_321", AW'(elem(m_array, 3, 2, 1)), AW'(8'hB7));
        check_val("gap_000", AW'(elem(m_array, 0, 0, 0)), AW'(8'hA0));
        cycle(1'b0, 8'h00, 1'b1);

        // Reset in the middle of a fill.
        for (int n = 0; n < 10; n++)
            cycle(1'b1, 8'($urandom), 1'b1);
        do_reset();
        for (int n = 0; n < NE; n++)
            cycle(1'b1, 8'(8'h10 + n), 1'b1);
        check_val("rfill_000", AW'(elem(m_array, 0, 0, 0)), AW'(8'h10));
        check_val("rfill_321", AW'(elem(m_array, 3, 2, 1)), AW'(8'h27));
        cycle(1'b0, 8'h00, 1'b1);
        check_val("wrap_0", AW'(frames_w), AW'(wrap_seq[0]));

        // Narrow counter wrap over four more frames.
        for (int f = 1; f < 5; f++) begin
            run_frame("wrap");
            check_val("wrap_seq", AW'(frames_w), AW'(wrap_seq[f]));
        end
        check_val("wide_frames", AW'(frames), AW'(5));

`ifdef ARRAY_PACKED_3D_ASSEMBLER_ZERO_BUBBLE_EN
        do_reset();
        hs_cnt = 0;
        for (int n = 0; n < 3 * NE; n++)
            cycle(1'b1, 8'($urandom), 1'b1);
        check_val("zb_handshakes", AW'(hs_cnt), AW'(3 * NE));
        cycle(1'b0, 8'h00, 1'b1);
        check_val("zb_frames", AW'(frames), AW'(3));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/array_packed_3d_assembler.md
Name: array_packed_3d_assembler

Overview:
- Downstream-facing producer of a packed 3D array `[DI-1:0][DJ-1:0][DK-1:0][DW-1:0]`, built from a scalar element stream.
- Accepts one DW-bit element per valid/ready handshake.
- Writes elements in nested order: k fastest, then j, then i, starting at [0][0][0].
- When the last element is written, presents the whole array on a valid/ready output port. Consumers take the completed array as one word.

Parameters:
- DI, 4, size of dimension 1 (slowest index i)
- DJ, 3, size of dimension 2 (index j)
- DK, 2, size of dimension 3 (fastest index k)
- DW, 8, element width in bits
- CW, 16, width of the completed-frame counter

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- s_valid  input  1  element valid
- s_ready  output  1  element ready
- s_data  input  DW  element value
- m_valid  output  1  array valid
- m_ready  input  1  array ready
- m_array  output  DI*DJ*DK*DW  packed array [DI-1:0][DJ-1:0][DK-1:0][DW-1:0]
- frames  output  CW  count of completed array handoffs
- busy  output  1  at least one element of the current frame accepted, frame not yet complete

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=FILL, indices i=j=k=0
  - m_valid=0, frames=0, busy=0
  - m_array all zeros
  - s_ready held 0 while rst_n is low
- States:
  - FILL: s_ready=1. On s_valid&&s_ready, write m_array[i][j][k]<=s_data and advance the index.
    - k increments; at DK-1 k wraps to 0 and j increments.
    - At DJ-1 j wraps to 0 and i increments.
    - Last element is i=DI-1, j=DJ-1, k=DK-1.
  - FILL->HOLD on the last-element handshake.
    - m_valid=1 the following cycle (latency 1 from the last handshake).
    - Indices return to 0.
  - HOLD: s_ready=0, m_valid=1, m_array stable.
  - HOLD->FILL on m_valid&&m_ready.
    - m_valid=0 the next cycle.
    - frames increments and wraps modulo 2^CW.
- m_array is never cleared after a handoff. The next frame overwrites it element by element, so partially filled content mixes old and new data.
- busy=1 in FILL when any of i, j, k is non-zero. busy=0 in HOLD and after reset.
- s_valid low cycles (gaps) stall indexing; no timeout.
- s_data is ignored when no handshake occurs.
- Index counters are sized $clog2 of each dimension, minimum 1 bit. Dimensions of size 1 never increment.
- Reset mid-fill or mid-hold aborts the frame: all state returns to reset values and no handoff is counted.

Optional Feature:
- Macro: ARRAY_PACKED_3D_ASSEMBLER_ZERO_BUBBLE_EN.
- When defined:
  - In HOLD, s_ready=m_ready (combinational).
  - A simultaneous output handoff and input handshake writes s_data to [0][0][0] of the new frame.
  - Next state is FILL with k=1, or with the index advanced as normal if DK=1. If DI=DJ=DK=1, next state is HOLD again.
  - Sustained throughput is one element per cycle.
- When undefined: s_ready=0 throughout HOLD, giving at least one bubble cycle per frame.

Decomposition:
- Package array_packed_3d_pkg holds:
  - default dimension localparams
  - state enum (FILL, HOLD)
  - element typedef logic [DW-1:0]
  - packed array typedef for the defaults
- Sub-module array_packed_3d_index:
  - parameterised nested i/j/k counter
  - inputs: increment enable, synchronous clear
  - outputs: i, j, k, last flag (combinational: current index is the final element)
  - async active-low reset

Test Plan:
- Full frame: stream 24 elements with value i+j+k, s_valid constantly high, m_ready=1 → m_valid rises 1 cycle after the 24th handshake; m_array[3][2][1]=6, m_array[0][0][0]=0, m_array[2][1][0]=3; frames=1.
- Backpressure: complete a frame, hold m_ready=0 for 5 cycles → s_ready=0 and m_array stable all 5 cycles; raise m_ready → m_valid=0 and s_ready=1 next cycle.
- Gaps: insert random s_valid=0 cycles (50%) while streaming 0xA0..0xB7 → m_array[i][j][k]=0xA0+i*6+j*2+k; busy=1 until the handoff.
- Reset mid-fill: assert rst_n=0 after 10 elements, release → m_array=0, busy=0, frames=0; the next 24 elements fill from [0][0][0].
- Counter wrap: CW=2, complete 5 frames → frames sequence 1,2,3,0,1.
- With ZERO_BUBBLE_EN: s_valid and m_ready held high for 3 frames → 72 handshakes in 72 consecutive cycles; each frame's m_array is correct; frames=3.
